// File: rtl/frame_grabber.sv
// Single-frame capture engine: arms on request, stores one WIDTH x HEIGHT frame in
// block RAM, then streams it (optional 6-byte header, little-endian pixels) over valid/ready.
module frame_grabber #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int PIX_BITS = 8,
    parameter int HEADER   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                frame_start,
    input  logic                frame_end,
    input  logic                line_start,
    input  logic                pix_valid,
    input  logic [PIX_BITS-1:0] pix_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = $clog2(DEPTH + 1);
    localparam int BPP   = (PIX_BITS + 7) / 8;
    localparam int TOTAL = ((HEADER != 0) ? 6 : 0) + DEPTH * BPP;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [47:0] HDR_VEC = {16'(HEIGHT), 16'(WIDTH), 16'h5AA5};

    typedef enum logic [1:0] {IDLE, WAIT_FS, CAPTURE, DUMP} state_t;

    state_t              state_q;
    logic [12:0]         x_q, y_q;
    logic [BW-1:0]       base_q;
    logic                first_line_q;
    logic                overflow_q;
    logic [AW-1:0]       rd_addr_q;
    logic                rd_ok_q;
    logic [1:0]          bidx_q;
    logic                hdr_phase_q;
    logic [2:0]          hdr_idx_q;
    logic [CW-1:0]       load_cnt_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                busy_q;
    logic                done_q;
    logic [PIX_BITS-1:0] rdata_q;
    logic [PIX_BITS-1:0] mem [DEPTH];

    logic [12:0]         x_d, y_d;
    logic [BW-1:0]       base_d;
    logic                wr_en;
    logic                drop;
    logic [AW-1:0]       wr_addr;
    logic [BPP*8-1:0]    pix_wide;
    logic [7:0]          pix_byte;
    logic [7:0]          hdr_byte;
    logic                more;
    logic                accept;
    logic                can_load;

    // A pixel arriving together with line_start belongs to the new line.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        base_d = base_q;
        if (line_start) begin
            x_d = '0;
            if (!first_line_q && (y_q < 13'(HEIGHT))) begin
                y_d    = y_q + 13'd1;
                base_d = base_q + BW'(WIDTH);
            end
        end
    end

    assign wr_en   = (state_q == CAPTURE) && pix_valid && (x_d < 13'(WIDTH)) && (y_d < 13'(HEIGHT));
    assign drop    = (state_q == CAPTURE) && pix_valid && !wr_en;
    assign wr_addr = AW'(base_d + BW'(x_d));

    assign pix_wide = (BPP*8)'(rdata_q);
    assign pix_byte = 8'(pix_wide >> {bidx_q, 3'b000});
    assign hdr_byte = 8'(HDR_VEC >> {hdr_idx_q, 3'b000});
    assign more     = (load_cnt_q != CW'(TOTAL));
    assign accept   = tx_valid_q && tx_ready;
    assign can_load = (state_q == DUMP) && more && (!tx_valid_q || tx_ready) && (hdr_phase_q || rd_ok_q);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= pix_data;
        end
        rdata_q <= mem[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            base_q       <= '0;
            first_line_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_ok_q      <= 1'b0;
            bidx_q       <= '0;
            hdr_phase_q  <= 1'b0;
            hdr_idx_q    <= '0;
            load_cnt_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_ok_q <= 1'b1;
            if (done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q <= WAIT_FS;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_FS: begin
                    if (frame_start) begin
                        state_q      <= CAPTURE;
                        x_q          <= '0;
                        y_q          <= '0;
                        base_q       <= '0;
                        first_line_q <= 1'b1;
                        overflow_q   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    x_q    <= wr_en ? x_d + 13'd1 : x_d;
                    y_q    <= y_d;
                    base_q <= base_d;
                    if (line_start) begin
                        first_line_q <= 1'b0;
                    end
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    // The read of pixel 0 is issued in the first DUMP cycle, after any final write.
                    if (frame_end) begin
                        state_q     <= DUMP;
                        rd_addr_q   <= '0;
                        rd_ok_q     <= 1'b0;
                        bidx_q      <= '0;
                        hdr_phase_q <= (HEADER != 0);
                        hdr_idx_q   <= '0;
                        load_cnt_q  <= '0;
                    end
                end
                DUMP: begin
                    if (can_load) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= hdr_phase_q ? hdr_byte : pix_byte;
                        load_cnt_q <= load_cnt_q + CW'(1);
                        if (hdr_phase_q) begin
                            hdr_idx_q <= hdr_idx_q + 3'd1;
                            if (hdr_idx_q == 3'd5) begin
                                hdr_phase_q <= 1'b0;
                            end
                        end else if (bidx_q == 2'(BPP - 1)) begin
                            bidx_q <= '0;
                            if (rd_addr_q != AW'(DEPTH - 1)) begin
                                rd_addr_q <= rd_addr_q + AW'(1);
                                rd_ok_q   <= 1'b0;
                            end
                        end else begin
                            bidx_q <= bidx_q + 2'd1;
                        end
                    end else if (accept) begin
                        tx_valid_q <= 1'b0;
                    end
                    if (accept && !more) begin
                        state_q    <= IDLE;
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
